gshare_bht: RTL and testbench



---
 rtl/gshare_bht.sv | 91 +++++++++
 tb/tb_gshare_bht.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_bht.sv
// gshare branch history table: 2-bit counters indexed by pc xor ghr,
// registered lookup with same-cycle update bypass and perf counters.
module gshare_bht #(
   parameter int IDX_W  = 6,
   parameter int GHR_W  = 6,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              lookup_en,
   input  logic [31:0]       lookup_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              update_en,
   input  logic [IDX_W-1:0]  update_idx,
   input  logic              update_taken,
   input  logic              update_mispred,
   output logic [GHR_W-1:0]  ghr,
   output logic [PERF_W-1:0] perf_lookups,
   output logic [PERF_W-1:0] perf_mispreds
);

   localparam int NENT = 1 << IDX_W;

   logic [1:0]       cnt_q [NENT];
   logic [IDX_W-1:0] lk_idx;
   logic [1:0]       cur_cnt;
   logic [1:0]       nxt_cnt;
   logic [1:0]       rd_cnt;
   logic             unused_pc;

   assign unused_pc = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

   always_comb begin
      lk_idx  = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr);
      cur_cnt = cnt_q[update_idx];
      nxt_cnt = cur_cnt;
      if (update_taken) begin
         if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'b01;
      end else begin
         if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'b01;
      end
      // a lookup colliding with this cycle's update sees the new value
      rd_cnt = cnt_q[lk_idx];
      if (update_en && (update_idx == lk_idx)) rd_cnt = nxt_cnt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NENT; i++) cnt_q[i] <= 2'b01;
      end else if (update_en) begin
         cnt_q[update_idx] <= nxt_cnt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ghr <= '0;
      end else if (update_en) begin
         ghr <= GHR_W'({ghr, update_taken});
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_idx   <= '0;
      end else begin
         pred_valid <= lookup_en;
         if (lookup_en) begin
            pred_taken <= rd_cnt[1];
            pred_idx   <= lk_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_lookups  <= '0;
         perf_mispreds <= '0;
      end else begin
         if (lookup_en && (perf_lookups != '1))
            perf_lookups <= perf_lookups + 1'b1;
         if (update_en && update_mispred && (perf_mispreds != '1))
            perf_mispreds <= perf_mispreds + 1'b1;
      end
   end

endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht: saturation, ghr hashing, bypass,
// perf saturation and asynchronous reset.
module tb_gshare_bht;

   logic        clk;
   logic        reset_n;
   logic        lookup_en;
   logic [31:0] lookup_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [5:0]  pred_idx;
   logic        update_en;
   logic [5:0]  update_idx;
   logic        update_taken;
   logic        update_mispred;
   logic [5:0]  ghr;
   logic [3:0]  perf_lookups;
   logic [3:0]  perf_mispreds;

   int          n_chk;
   int          n_err;
   logic [5:0]  exp_ghr;

   gshare_bht #(.IDX_W(6), .GHR_W(6), .PERF_W(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .lookup_en      (lookup_en),
      .lookup_pc      (lookup_pc),
      .pred_valid     (pred_valid),
      .pred_taken     (pred_taken),
      .pred_idx       (pred_idx),
      .update_en      (update_en),
      .update_idx     (update_idx),
      .update_taken   (update_taken),
      .update_mispred (update_mispred),
      .ghr            (ghr),
      .perf_lookups   (perf_lookups),
      .perf_mispreds  (perf_mispreds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pc_of(input logic [5:0] idx);
      return {24'h0, idx ^ exp_ghr, 2'b00};
   endfunction

   task automatic upd(input logic [5:0] idx,
                      input logic tk,
                      input logic mis);
      update_en      = 1'b1;
      update_idx     = idx;
      update_taken   = tk;
      update_mispred = mis;
      tick();
      update_en      = 1'b0;
      update_mispred = 1'b0;
      exp_ghr        = {exp_ghr[4:0], tk};
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_en = 1'b1;
      lookup_pc = pc;
      tick();
      lookup_en = 1'b0;
   endtask

   initial begin
      n_chk          = 0;
      n_err          = 0;
      exp_ghr        = '0;
      reset_n        = 1'b0;
      lookup_en      = 1'b0;
      lookup_pc      = '0;
      update_en      = 1'b0;
      update_idx     = '0;
      update_taken   = 1'b0;
      update_mispred = 1'b0;
      repeat (2) tick();
      chk("rst_valid", pred_valid, 0);
      chk("rst_taken", pred_taken, 0);
      chk("rst_idx", pred_idx, 0);
      chk("rst_ghr", ghr, 0);
      chk("rst_plk", perf_lookups, 0);
      chk("rst_pmp", perf_mispreds, 0);
      reset_n = 1'b1;

      look(32'h40);
      chk("first_valid", pred_valid, 1);
      chk("first_taken", pred_taken, 0);
      chk("first_idx", pred_idx, 6'h10);
      chk("first_ghr", ghr, 0);
      chk("first_plk", perf_lookups, 1);
      tick();
      chk("idle_valid", pred_valid, 0);
      chk("hold_idx", pred_idx, 6'h10);

      // counter 5: 01 -> saturate at 11
      repeat (4) upd(6'd5, 1'b1, 1'b0);
      chk("sat_ghr", ghr, 6'h0F);
      look(pc_of(6'd5));
      chk("sat_hi_idx", pred_idx, 6'd5);
      chk("sat_hi_tk", pred_taken, 1);
      upd(6'd5, 1'b0, 1'b0);
      look(pc_of(6'd5));
      chk("dec_10_tk", pred_taken, 1);
      upd(6'd5, 1'b0, 1'b0);
      chk("dec_ghr", ghr, 6'h3C);
      look(pc_of(6'd5));
      chk("dec_01_tk", pred_taken, 0);
      for (int i = 0; i < 5; i++) begin
         upd(6'd5, 1'b0, 1'b0);
         look(pc_of(6'd5));
         chk("sat_lo_tk", pred_taken, 0);
      end
      upd(6'd5, 1'b1, 1'b0);
      look(pc_of(6'd5));
      chk("inc_01_tk", pred_taken, 0);
      upd(6'd5, 1'b1, 1'b0);
      look(pc_of(6'd5));
      chk("inc_10_tk", pred_taken, 1);

      // dirty entries, then async reset between clock edges
      upd(6'd5, 1'b1, 1'b0);
      upd(6'h1B, 1'b0, 1'b1);
      chk("pre_pmp", perf_mispreds, 1);
      lookup_en = 1'b1;
      lookup_pc = 32'h40;
      tick();
      chk("pre_valid", pred_valid, 1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", pred_valid, 0);
      chk("arst_ghr", ghr, 0);
      chk("arst_plk", perf_lookups, 0);
      chk("arst_pmp", perf_mispreds, 0);
      tick();
      chk("arst_hold", pred_valid, 0);
      reset_n   = 1'b1;
      lookup_en = 1'b0;
      exp_ghr   = '0;

      look(32'h14);
      chk("post_idx", pred_idx, 6'd5);
      chk("post_tk5", pred_taken, 0);
      chk("post_plk", perf_lookups, 1);

      upd(6'h30, 1'b1, 1'b0);
      upd(6'h30, 1'b0, 1'b0);
      upd(6'h30, 1'b1, 1'b0);
      upd(6'h30, 1'b1, 1'b0);
      chk("ghr_seq", ghr, 6'b001011);
      look(32'h40);
      chk("ghr_idx", pred_idx, 6'h1B);
      chk("ghr_tk", pred_taken, 0);

      // same-cycle update and lookup of entry 0x1B
      lookup_en    = 1'b1;
      lookup_pc    = 32'h40;
      update_en    = 1'b1;
      update_idx   = 6'h1B;
      update_taken = 1'b1;
      tick();
      exp_ghr = {exp_ghr[4:0], 1'b1};
      chk("byp_idx", pred_idx, 6'h1B);
      chk("byp_tk", pred_taken, 1);
      chk("byp_ghr", ghr, 6'h17);
      lookup_pc    = pc_of(6'h2A);
      update_idx   = 6'h1B;
      update_taken = 1'b1;
      tick();
      exp_ghr = {exp_ghr[4:0], 1'b1};
      update_en = 1'b0;
      lookup_en = 1'b0;
      chk("nobyp_idx", pred_idx, 6'h2A);
      chk("nobyp_tk", pred_taken, 0);
      look(pc_of(6'h1B));
      chk("after_byp", pred_taken, 1);

      update_mispred = 1'b1;
      repeat (3) tick();
      update_mispred = 1'b0;
      chk("mis_noen", perf_mispreds, 0);
      upd(6'h01, 1'b0, 1'b1);
      upd(6'h01, 1'b0, 1'b1);
      chk("mis_two", perf_mispreds, 2);
      lookup_en = 1'b1;
      repeat (20) tick();
      lookup_en = 1'b0;
      chk("plk_sat", perf_lookups, 4'hF);
      repeat (15) upd(6'h02, 1'b1, 1'b1);
      chk("pmp_sat", perf_mispreds, 4'hF);
      chk("end_ghr", ghr, exp_ghr);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
